// File: rtl/writeback_sq.sv
// writeback_sq: x86 writeback stage with an in-order store queue.
//
// Retires one instruction per cycle into architectural state (GPR, MMX,
// segment, flags, EIP). Each write port is registered, so it updates one
// cycle after the instruction is accepted.
//
// Memory writes are placed in a SQ_DEPTH-entry FIFO. The FIFO drains to
// the dcache over a valid/ready handshake. Serialising instructions are
// held until the FIFO is empty.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wb_*                  instruction presented at writeback
//   wb_ready              instruction accepted this cycle
//   MEM_write_stall       wb_valid & ~wb_ready
//   gpr/mm/seg/flags/eip  registered architectural write ports
//   dc_req_*, dc_*        store drain to the dcache
//   sq_count, sq_empty    FIFO occupancy
module writeback_sq #(
  parameter int ADDR_W   = 32,
  parameter int SQ_DEPTH = 4,
  parameter int CNT_W    = $clog2(SQ_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              wb_ld_gpr,
  input  logic              wb_ld_mm,
  input  logic              wb_ld_seg,
  input  logic              wb_ld_flags,
  input  logic              wb_ld_eip,
  input  logic              wb_mem_write,
  input  logic              wb_serialize,
  input  logic [2:0]        wb_dr,
  input  logic [2:0]        wb_mm_dr,
  input  logic [2:0]        wb_seg_id,
  input  logic [1:0]        wb_data_size,
  input  logic [ADDR_W-1:0] wb_address,
  input  logic [31:0]       wb_result,
  input  logic [63:0]       wb_mm_result,
  input  logic [31:0]       wb_flags,
  input  logic [31:0]       wb_eip,
  input  logic [15:0]       wb_cs,
  output logic              wb_ready,
  output logic              MEM_write_stall,
  output logic              gpr_we,
  output logic [2:0]        gpr_addr,
  output logic [31:0]       gpr_data,
  output logic              mm_we,
  output logic [2:0]        mm_addr,
  output logic [63:0]       mm_data,
  output logic              seg_we,
  output logic [2:0]        seg_addr,
  output logic [15:0]       seg_data,
  output logic              flags_we,
  output logic [31:0]       flags_data,
  output logic              eip_we,
  output logic [31:0]       eip_data,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [63:0]       dc_data,
  output logic [1:0]        dc_size,
  output logic [CNT_W-1:0]  sq_count,
  output logic              sq_empty
);

  localparam int PTR_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;

  logic [ADDR_W-1:0] sq_addr_q [SQ_DEPTH];
  logic [ADDR_W-1:0] sq_addr_d [SQ_DEPTH];
  logic [63:0]       sq_data_q [SQ_DEPTH];
  logic [63:0]       sq_data_d [SQ_DEPTH];
  logic [1:0]        sq_size_q [SQ_DEPTH];
  logic [1:0]        sq_size_d [SQ_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic        gpr_we_q, gpr_we_d, mm_we_q, mm_we_d, seg_we_q, seg_we_d;
  logic        flags_we_q, flags_we_d, eip_we_q, eip_we_d;
  logic [2:0]  gpr_addr_q, gpr_addr_d, mm_addr_q, mm_addr_d, seg_addr_q, seg_addr_d;
  logic [31:0] gpr_data_q, gpr_data_d, flags_data_q, flags_data_d, eip_data_q, eip_data_d;
  logic [63:0] mm_data_q, mm_data_d;
  logic [15:0] seg_data_q, seg_data_d;

  logic        full, empty, accept, enq, deq;
  logic [63:0] st_data;

  // Stall decisions use the registered count only, so a full queue never
  // accepts a store even in a cycle where the head is draining.
  assign empty           = (count_q == '0);
  assign full            = (count_q == CNT_W'(SQ_DEPTH));
  assign wb_ready        = ~(wb_valid & wb_mem_write & full) &
                           ~(wb_valid & wb_serialize & ~empty);
  assign MEM_write_stall = wb_valid & ~wb_ready;
  assign accept          = wb_valid & wb_ready;
  assign enq             = accept & wb_mem_write;
  assign deq             = ~empty & dc_req_ready;

  // Store data is zero-extended above the access size.
  always_comb begin
    st_data = 64'd0;
    case (wb_data_size)
      2'd0:    st_data = {56'd0, wb_result[7:0]};
      2'd1:    st_data = {48'd0, wb_result[15:0]};
      2'd2:    st_data = {32'd0, wb_result};
      default: st_data = wb_mm_result;
    endcase
  end

  // SQ_DEPTH is a power of two, so pointer increment wraps naturally.
  always_comb begin
    sq_addr_d = sq_addr_q;
    sq_data_d = sq_data_q;
    sq_size_d = sq_size_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (enq) begin
      sq_addr_d[tail_q] = wb_address;
      sq_data_d[tail_q] = st_data;
      sq_size_d[tail_q] = wb_data_size;
      tail_d            = tail_q + 1'b1;
    end
    if (deq) begin
      head_d = head_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Write enables pulse for one cycle; data/addr hold when nothing retires.
  always_comb begin
    gpr_we_d     = accept & wb_ld_gpr;
    mm_we_d      = accept & wb_ld_mm;
    seg_we_d     = accept & wb_ld_seg;
    flags_we_d   = accept & wb_ld_flags;
    eip_we_d     = accept & wb_ld_eip;
    gpr_addr_d   = accept ? wb_dr        : gpr_addr_q;
    gpr_data_d   = accept ? wb_result    : gpr_data_q;
    mm_addr_d    = accept ? wb_mm_dr     : mm_addr_q;
    mm_data_d    = accept ? wb_mm_result : mm_data_q;
    seg_addr_d   = accept ? wb_seg_id    : seg_addr_q;
    seg_data_d   = accept ? wb_cs        : seg_data_q;
    flags_data_d = accept ? wb_flags     : flags_data_q;
    eip_data_d   = accept ? wb_eip       : eip_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        sq_addr_q[i] <= '0;
        sq_data_q[i] <= '0;
        sq_size_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      gpr_we_q     <= 1'b0;
      mm_we_q      <= 1'b0;
      seg_we_q     <= 1'b0;
      flags_we_q   <= 1'b0;
      eip_we_q     <= 1'b0;
      gpr_addr_q   <= '0;
      gpr_data_q   <= '0;
      mm_addr_q    <= '0;
      mm_data_q    <= '0;
      seg_addr_q   <= '0;
      seg_data_q   <= '0;
      flags_data_q <= '0;
      eip_data_q   <= '0;
    end else begin
      sq_addr_q    <= sq_addr_d;
      sq_data_q    <= sq_data_d;
      sq_size_q    <= sq_size_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      gpr_we_q     <= gpr_we_d;
      mm_we_q      <= mm_we_d;
      seg_we_q     <= seg_we_d;
      flags_we_q   <= flags_we_d;
      eip_we_q     <= eip_we_d;
      gpr_addr_q   <= gpr_addr_d;
      gpr_data_q   <= gpr_data_d;
      mm_addr_q    <= mm_addr_d;
      mm_data_q    <= mm_data_d;
      seg_addr_q   <= seg_addr_d;
      seg_data_q   <= seg_data_d;
      flags_data_q <= flags_data_d;
      eip_data_q   <= eip_data_d;
    end
  end

  assign gpr_we     = gpr_we_q;
  assign gpr_addr   = gpr_addr_q;
  assign gpr_data   = gpr_data_q;
  assign mm_we      = mm_we_q;
  assign mm_addr    = mm_addr_q;
  assign mm_data    = mm_data_q;
  assign seg_we     = seg_we_q;
  assign seg_addr   = seg_addr_q;
  assign seg_data   = seg_data_q;
  assign flags_we   = flags_we_q;
  assign flags_data = flags_data_q;
  assign eip_we     = eip_we_q;
  assign eip_data   = eip_data_q;

  // The drain side is driven purely from registered queue state.
  assign dc_req_valid = ~empty;
  assign dc_addr      = sq_addr_q[head_q];
  assign dc_data      = sq_data_q[head_q];
  assign dc_size      = sq_size_q[head_q];
  assign sq_count     = count_q;
  assign sq_empty     = empty;

endmodule
